// File: rtl/alu_redundancy_scheduler.sv
// Time-redundant execution sequencer: each ALU operation runs twice, a third time on mismatch,
// and the result is taken by majority vote. Repeated faults switch the source to the spare ALU.
module alu_redundancy_scheduler #(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 8,
  parameter int PERM_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       alu_op,
  output logic             ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] spare_result,
  output logic             stall_out,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic             fault_detected,
  output logic             uncorrectable,
  output logic [CNT_W-1:0] fault_count,
  output logic             use_spare,
  output logic             hw_fault_flag,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE, RUN1, RUN2, RUN3} state_t;

  localparam int CONS_W = $clog2(PERM_THRESH + 1);
  localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(PERM_THRESH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [2:0]         alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0]   r1_q, r1_d;
  logic [WIDTH-1:0]   r2_q, r2_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic               uncorr_q, uncorr_d;
  logic [CNT_W-1:0]   fault_count_q, fault_count_d;
  logic [CONS_W-1:0]  consec_q, consec_d;
  logic               use_spare_q, use_spare_d;
  logic [WIDTH-1:0]   src;

  assign src = use_spare_q ? spare_result : alu_result;

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_ctrl_d    = alu_ctrl_q;
    r1_d          = r1_q;
    r2_d          = r2_q;
    result_d      = result_q;
    done_d        = 1'b0;
    fault_d       = 1'b0;
    uncorr_d      = 1'b0;
    fault_count_d = fault_count_q;
    consec_d      = consec_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          alu_a_d    = op_a;
          alu_b_d    = op_b;
          alu_ctrl_d = alu_op;
          state_d    = RUN1;
        end
      end
      RUN1: begin
        r1_d    = src;
        state_d = RUN2;
      end
      RUN2: begin
        r2_d = src;
        if (src == r1_q) begin
          result_d = src;
          done_d   = 1'b1;
          consec_d = '0;
          state_d  = IDLE;
        end else begin
          fault_d = 1'b1;
          if (fault_count_q != CNT_MAX) fault_count_d = fault_count_q + CNT_W'(1);
          if (consec_q != CONS_MAX) consec_d = consec_q + CONS_W'(1);
          state_d = RUN3;
        end
      end
      RUN3: begin
        // Third run is the tie-breaker; if it matches neither, nothing can be trusted.
        if (src == r1_q) begin
          result_d = r1_q;
        end else if (src == r2_q) begin
          result_d = r2_q;
        end else begin
          result_d = src;
          uncorr_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    use_spare_d = use_spare_q | (consec_d == CONS_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_ctrl_q    <= '0;
      r1_q          <= '0;
      r2_q          <= '0;
      result_q      <= '0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      uncorr_q      <= 1'b0;
      fault_count_q <= '0;
      consec_q      <= '0;
      use_spare_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_ctrl_q    <= alu_ctrl_d;
      r1_q          <= r1_d;
      r2_q          <= r2_d;
      result_q      <= result_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
      uncorr_q      <= uncorr_d;
      fault_count_q <= fault_count_d;
      consec_q      <= consec_d;
      use_spare_q   <= use_spare_d;
    end
  end

  // Stall starts combinationally with an accepted start so the pipeline freezes in the start cycle.
  assign ready          = (state_q == IDLE);
  assign stall_out      = (state_q != IDLE) | (start & ready);
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_ctrl       = alu_ctrl_q;
  assign done           = done_q;
  assign result_out     = result_q;
  assign fault_detected = fault_q;
  assign uncorrectable  = uncorr_q;
  assign fault_count    = fault_count_q;
  assign use_spare      = use_spare_q;
  assign hw_fault_flag  = use_spare_q;
  assign dbg_state      = state_q;

endmodule
